// File: rtl/datapath_arbiter_if.sv
// Handshake bundle between requesters, the round-robin datapath arbiter and the
// start/done datapath controller it sequences.
interface datapath_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int CW  = 8
);
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           err;
    logic           dp_start;
    logic           dp_done;
    logic           dp_abort;
    logic           busy;
    logic [IDW-1:0] cur_id;
    logic [CW-1:0]  op_cycles;

    modport slave (
        input  req,
        input  dp_done,
        output gnt,
        output ack,
        output err,
        output dp_start,
        output dp_abort,
        output busy,
        output cur_id,
        output op_cycles
    );

    modport master (
        output req,
        output dp_done,
        input  gnt,
        input  ack,
        input  err,
        input  dp_start,
        input  dp_abort,
        input  busy,
        input  cur_id,
        input  op_cycles
    );
endinterface

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing one start/done datapath controller among N requesters.
// Optional WAIT timeout with abort is enabled by defining ARB_TIMEOUT_EN.
module datapath_arbiter #(
    parameter int          N       = 4,
    parameter int          IDW     = 2,
    parameter int          CW      = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst,
    datapath_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [N-1:0]   ZERO_N     = {N{1'b0}};
    localparam logic [N-1:0]   ONE_N      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] ZERO_ID    = {IDW{1'b0}};
    localparam logic [IDW-1:0] ID_LAST    = IDW'(N - 1);
    localparam logic [CW-1:0]  ZERO_CNT   = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0]  TIMEOUT_OP = (TIMEOUT > 32'(CNT_MAX)) ? CNT_MAX : CW'(TIMEOUT);

    state_t         state_r, state_next_s;
    logic [IDW-1:0] rr_ptr_r, rr_ptr_next_s;
    logic [IDW-1:0] cur_id_r, cur_id_next_s;
    logic [CW-1:0]  wait_cnt_r, wait_cnt_next_s;
    logic [CW-1:0]  op_cycles_r, op_cycles_next_s;
    logic [N-1:0]   gnt_r, gnt_next_s;
    logic [N-1:0]   ack_r, ack_next_s;
    logic           err_r, err_next_s;
    logic           dp_start_r, dp_start_next_s;
    logic           dp_abort_r, dp_abort_next_s;
    logic           busy_r, busy_next_s;

    logic [IDW-1:0] pick_s;
    logic [N-1:0]   pick_oh_s;
    logic [N-1:0]   cur_oh_s;
    logic           timeout_hit_s;

    // First requesting index at or after ptr, wrapping N-1 -> 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = ZERO_ID;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && r[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    assign pick_s        = rr_pick(bus.req, rr_ptr_r);
    assign pick_oh_s     = ONE_N << pick_s;
    assign cur_oh_s      = ONE_N << cur_id_r;
    // The increment that would reach TIMEOUT aborts, so WAIT lasts at most TIMEOUT cycles.
    assign timeout_hit_s = TIMEOUT_EN && ((32'(wait_cnt_r) + 32'd1) >= TIMEOUT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next-output decode; dp_done takes priority over timeout.
    always_comb begin
        state_next_s     = state_r;
        rr_ptr_next_s    = rr_ptr_r;
        cur_id_next_s    = cur_id_r;
        wait_cnt_next_s  = wait_cnt_r;
        op_cycles_next_s = op_cycles_r;
        gnt_next_s       = gnt_r;
        ack_next_s       = ZERO_N;
        err_next_s       = err_r;
        dp_start_next_s  = 1'b0;
        dp_abort_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_next_s    = ST_START;
                    cur_id_next_s   = pick_s;
                    gnt_next_s      = pick_oh_s;
                    dp_start_next_s = 1'b1;
                end else begin
                    gnt_next_s      = ZERO_N;
                end
            end
            ST_START: begin
                state_next_s    = ST_WAIT;
                wait_cnt_next_s = ZERO_CNT;
            end
            ST_WAIT: begin
                if (bus.dp_done) begin
                    state_next_s     = ST_ACK;
                    op_cycles_next_s = wait_cnt_r;
                    ack_next_s       = cur_oh_s;
                end else if (timeout_hit_s) begin
                    state_next_s     = ST_ABORT;
                    op_cycles_next_s = TIMEOUT_OP;
                    dp_abort_next_s  = 1'b1;
                    err_next_s       = 1'b1;
                end else if (wait_cnt_r != CNT_MAX) begin
                    wait_cnt_next_s  = wait_cnt_r + CW'(1'b1);
                end else begin
                    wait_cnt_next_s  = wait_cnt_r;
                end
            end
            ST_ABORT: begin
                state_next_s = ST_ACK;
                ack_next_s   = cur_oh_s;
                err_next_s   = 1'b1;
            end
            ST_ACK: begin
                state_next_s  = ST_IDLE;
                gnt_next_s    = ZERO_N;
                err_next_s    = 1'b0;
                rr_ptr_next_s = (cur_id_r == ID_LAST) ? ZERO_ID : cur_id_r + IDW'(1'b1);
            end
            default: begin
                state_next_s = ST_IDLE;
                gnt_next_s   = ZERO_N;
                err_next_s   = 1'b0;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // Registered outputs and job bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= ZERO_ID;
            cur_id_r    <= ZERO_ID;
            wait_cnt_r  <= ZERO_CNT;
            op_cycles_r <= ZERO_CNT;
            gnt_r       <= ZERO_N;
            ack_r       <= ZERO_N;
            err_r       <= 1'b0;
            dp_start_r  <= 1'b0;
            dp_abort_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rr_ptr_r    <= rr_ptr_next_s;
            cur_id_r    <= cur_id_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            op_cycles_r <= op_cycles_next_s;
            gnt_r       <= gnt_next_s;
            ack_r       <= ack_next_s;
            err_r       <= err_next_s;
            dp_start_r  <= dp_start_next_s;
            dp_abort_r  <= dp_abort_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.ack       = ack_r;
    assign bus.err       = err_r;
    assign bus.dp_start  = dp_start_r;
    assign bus.dp_abort  = dp_abort_r;
    assign bus.busy      = busy_r;
    assign bus.cur_id    = cur_id_r;
    assign bus.op_cycles = op_cycles_r;
endmodule

// File: tb/tb_datapath_arbiter.sv
// Randomised self-checking bench for datapath_arbiter with a transaction-level
// round-robin model; timeout expectations follow ARB_TIMEOUT_EN.
module tb_datapath_arbiter;
    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int CW    = 8;
    localparam int TB_TO = 10;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] req_v;
    int           rr_m;

    datapath_arbiter_if #(.N(N), .IDW(IDW), .CW(CW)) bus ();

    datapath_arbiter #(.N(N), .IDW(IDW), .CW(CW), .TIMEOUT(TB_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req_v = '0;
        bus.req = '0;
        bus.dp_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.dp_start !== 1'b0) begin errors++; $display("FAIL reset_dp_start: got %b expected 0", bus.dp_start); end
        checks++; if (bus.dp_abort !== 1'b0) begin errors++; $display("FAIL reset_dp_abort: got %b expected 0", bus.dp_abort); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.cur_id !== 2'd0) begin errors++; $display("FAIL reset_cur_id: got %0d expected 0", bus.cur_id); end
        checks++; if (bus.op_cycles !== 8'd0) begin errors++; $display("FAIL reset_op_cycles: got %0d expected 0", bus.op_cycles); end
        rst = 1'b0;
        rr_m = 0;
    endtask

    // Called at the negedge of an IDLE cycle with req_v non-zero; returns at the
    // negedge of the IDLE cycle following the job. dp_done goes high d cycles after dp_start.
    task automatic run_job(input int d, input bit keep_req, input bit noise, input bit drop, input string tag);
        int           w;
        logic [N-1:0] exp_oh;
        bit           aborted;
        int           wait_len;
        logic [CW-1:0] exp_op;
        w = model_pick(req_v, rr_m);
        exp_oh = '0;
        exp_oh[w] = 1'b1;
        aborted  = TO_EN && (d > TB_TO);
        wait_len = aborted ? TB_TO : d;
        exp_op   = aborted ? CW'(TB_TO) : CW'(d - 1);
        bus.req = req_v;

        @(negedge clk);
        checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL %s_start_gnt: got %b expected %b", tag, bus.gnt, exp_oh); end
        checks++; if (bus.dp_start !== 1'b1) begin errors++; $display("FAIL %s_start_pulse: got %b expected 1", tag, bus.dp_start); end
        checks++; if (bus.cur_id !== IDW'(w)) begin errors++; $display("FAIL %s_start_cur_id: got %0d expected %0d", tag, bus.cur_id, w); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_start_busy: got %b expected 1", tag, bus.busy); end
        bus.dp_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;

        for (int i = 1; i <= wait_len; i++) begin
            @(negedge clk);
            bus.dp_done = (!aborted && i == d);
            if (drop && i == 1) begin
                req_v[w] = 1'b0;
                bus.req = req_v;
            end
            checks++; if (bus.dp_start !== 1'b0) begin errors++; $display("FAIL %s_wait_start: got %b expected 0 (cycle %0d)", tag, bus.dp_start, i); end
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL %s_wait_ack: got %b expected 0000 (cycle %0d)", tag, bus.ack, i); end
            checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL %s_wait_gnt: got %b expected %b (cycle %0d)", tag, bus.gnt, exp_oh, i); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_wait_busy: got %b expected 1 (cycle %0d)", tag, bus.busy, i); end
        end

        if (aborted) begin
            @(negedge clk);
            bus.dp_done = 1'b0;
            checks++; if (bus.dp_abort !== 1'b1) begin errors++; $display("FAIL %s_abort_pulse: got %b expected 1", tag, bus.dp_abort); end
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL %s_abort_ack: got %b expected 0000", tag, bus.ack); end
            checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL %s_abort_gnt: got %b expected %b", tag, bus.gnt, exp_oh); end
        end

        @(negedge clk);
        checks++; if (bus.ack !== exp_oh) begin errors++; $display("FAIL %s_ack: got %b expected %b", tag, bus.ack, exp_oh); end
        checks++; if (bus.err !== aborted) begin errors++; $display("FAIL %s_ack_err: got %b expected %b", tag, bus.err, aborted); end
        checks++; if (bus.op_cycles !== exp_op) begin errors++; $display("FAIL %s_op_cycles: got %0d expected %0d", tag, bus.op_cycles, exp_op); end
        checks++; if (bus.dp_abort !== 1'b0) begin errors++; $display("FAIL %s_ack_abort: got %b expected 0", tag, bus.dp_abort); end
        checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL %s_ack_gnt: got %b expected %b", tag, bus.gnt, exp_oh); end
        bus.dp_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rr_m = (w + 1) % N;
        if (!keep_req) req_v[w] = 1'b0;
        bus.req = req_v;

        @(negedge clk);
        bus.dp_done = 1'b0;
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL %s_idle_ack: got %b expected 0000", tag, bus.ack); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL %s_idle_gnt: got %b expected 0000", tag, bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy: got %b expected 0", tag, bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL %s_idle_err: got %b expected 0", tag, bus.err); end
        checks++; if (bus.cur_id !== IDW'(w)) begin errors++; $display("FAIL %s_idle_cur_id: got %0d expected %0d", tag, bus.cur_id, w); end
    endtask

    task automatic test_single_job();
        req_v = 4'b0100;
        run_job(5, 1'b0, 1'b0, 1'b0, "single");
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        test_reset();
        req_v = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            run_job(2, 1'b1, 1'b0, 1'b0, "rr");
            checks++; if (bus.cur_id !== IDW'(order[j])) begin errors++; $display("FAIL rr_order: job %0d got %0d expected %0d", j, bus.cur_id, order[j]); end
        end
        req_v = '0;
        bus.req = req_v;
    endtask

    task automatic test_fairness_wrap();
        test_reset();
        req_v = 4'b0100;
        run_job(3, 1'b0, 1'b0, 1'b0, "wrap_a");
        req_v = 4'b0011;
        run_job(2, 1'b0, 1'b0, 1'b0, "wrap_b");
        checks++; if (bus.cur_id !== 2'd0) begin errors++; $display("FAIL wrap_first: got %0d expected 0", bus.cur_id); end
        run_job(2, 1'b0, 1'b0, 1'b0, "wrap_c");
        checks++; if (bus.cur_id !== 2'd1) begin errors++; $display("FAIL wrap_second: got %0d expected 1", bus.cur_id); end
    endtask

    task automatic test_reset_mid_job();
        test_reset();
        req_v = 4'b0010;
        run_job(2, 1'b0, 1'b0, 1'b0, "pre_rst");
        req_v = 4'b0100;
        bus.req = req_v;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req_v = '0;
        bus.req = req_v;
        @(negedge clk);
        rst = 1'b0;
        rr_m = 0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.cur_id !== 2'd0) begin errors++; $display("FAIL midrst_cur_id: got %0d expected 0", bus.cur_id); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL midrst_no_ack: got %b expected 0000", bus.ack); end
        end
        req_v = 4'b1010;
        run_job(4, 1'b0, 1'b0, 1'b0, "post_rst_a");
        checks++; if (bus.cur_id !== 2'd1) begin errors++; $display("FAIL midrst_ptr: got %0d expected 1", bus.cur_id); end
        run_job(1, 1'b0, 1'b0, 1'b0, "post_rst_b");
        checks++; if (bus.cur_id !== 2'd3) begin errors++; $display("FAIL midrst_next: got %0d expected 3", bus.cur_id); end
    endtask

    task automatic test_timeout();
        test_reset();
        req_v = 4'b0001;
        run_job(TB_TO + 1, 1'b0, 1'b0, 1'b0, "to_abort");
        req_v = 4'b0001;
        run_job(TB_TO, 1'b0, 1'b0, 1'b0, "to_edge");
        req_v = 4'b0010;
        run_job(3 * TB_TO, 1'b0, 1'b0, 1'b0, "to_long");
    endtask

    task automatic test_random();
        test_reset();
        for (int j = 0; j < 40; j++) begin
            req_v = req_v | 4'($urandom_range(0, 15));
            if (req_v == 4'b0000) req_v[$urandom_range(0, N - 1)] = 1'b1;
            run_job(int'($urandom_range(1, 14)), 1'($urandom_range(0, 1)), 1'b1,
                    ($urandom_range(0, 3) == 0), "rand");
        end
        req_v = '0;
        bus.req = req_v;
        @(negedge clk);
    endtask

    initial begin
        bus.req = '0;
        bus.dp_done = 1'b0;
        req_v = '0;
        rr_m = 0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_fairness_wrap();
        test_reset_mid_job();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
